// File: rtl/updown_bcd_pkg.sv
// Shared definitions for the multi-digit BCD up/down counter.
//
// Contents:
//   BCD_W         width of one BCD digit
//   BCD_MAX       largest legal digit value (9)
//   BCD_MIN       smallest legal digit value (0)
//   bcd_sanitize  maps an illegal nibble (>9) to 0, passes legal digits through
package updown_bcd_pkg;

  localparam int unsigned      BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'h9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'h0;

  function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MIN : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter chain.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-low reset, clears the digit to 0
//   step_en    a count step happens this cycle
//   up         1 = increment, 0 = decrement
//   load       synchronous load strobe (priority over step)
//   load_val   value to load; nibbles above 9 load as 0
//   carry_in   all lower digits are at the limit for the current direction
//   digit      current digit value (always 0..9)
//   carry_out  carry_in and this digit is at 9 (up) or 0 (down)
module bcd_digit
  import updown_bcd_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             step_en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out
);

  logic [BCD_W-1:0] digit_q, digit_d;
  logic             at_max, at_min;

  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_sanitize(load_val);
    end else if (step_en && carry_in) begin
      if (up) begin
        digit_d = at_max ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = at_min ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  // Carry is combinational so every digit of the chain updates on the same edge.
  assign carry_out = carry_in & (up ? at_max : at_min);

endmodule

// File: rtl/updown_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaler, synchronous load and wrap pulse.
//
// Parameters:
//   DIGITS          number of BCD digits (1..8), digit 0 least significant
//   TICK_MAX        prescaler period in CLK cycles (>=2)
//   OUT_ACTIVE_LOW  1 = COUNT inverted for active-low LEDs, 0 = true BCD
//
// Ports:
//   CLK       system clock, rising edge
//   RESET     synchronous active-low reset
//   RUN       1 = prescaler advances and counting enabled, 0 = hold
//   UP        count direction, only matters on the step cycle
//   LOAD      synchronous load strobe, clears the prescaler
//   LOAD_VAL  BCD load value, digit i at [4i+3:4i]
//   COUNT     current value, polarity per OUT_ACTIVE_LOW
//   TICK      one-cycle pulse per count step
//   WRAP      one-cycle pulse when a step crosses the full-value limit
//
// Build option: define UPDOWN_BCD_SATURATE_EN to saturate at 9..9 / 0..0 instead of
// wrapping; WRAP then pulses on every step attempted at the limit.
module updown_bcd_counter
  import updown_bcd_pkg::*;
#(
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned TICK_MAX       = 6000000,
  parameter int unsigned OUT_ACTIVE_LOW = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    RUN,
  input  logic                    UP,
  input  logic                    LOAD,
  input  logic [BCD_W*DIGITS-1:0] LOAD_VAL,
  output logic [BCD_W*DIGITS-1:0] COUNT,
  output logic                    TICK,
  output logic                    WRAP
);

  localparam int unsigned     PW         = $clog2(TICK_MAX);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_MAX - 1);

  logic [PW-1:0]             presc_q, presc_d;
  logic                      tick_q, tick_d;
  logic                      wrap_q, wrap_d;
  logic                      step;
  logic                      digit_step;
  logic                      at_limit;
  logic [DIGITS:0]           carry;
  logic [BCD_W*DIGITS-1:0]   value;

  assign step     = RUN && (presc_q == PRESC_LAST);
  assign carry[0] = 1'b1;
  // All digits at 9 (up) or 0 (down): this step crosses the full-value limit.
  assign at_limit = carry[DIGITS];

`ifdef UPDOWN_BCD_SATURATE_EN
  assign digit_step = step & ~at_limit;
`else
  assign digit_step = step;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .CLK       (CLK),
      .RESET     (RESET),
      .step_en   (digit_step),
      .up        (UP),
      .load      (LOAD),
      .load_val  (LOAD_VAL[BCD_W*i +: BCD_W]),
      .carry_in  (carry[i]),
      .digit     (value[BCD_W*i +: BCD_W]),
      .carry_out (carry[i+1])
    );
  end

  always_comb begin
    presc_d = presc_q;
    tick_d  = step;
    wrap_d  = step & at_limit;
    if (LOAD) begin
      presc_d = '0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
    end else if (step) begin
      presc_d = '0;
    end else if (RUN) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  if (OUT_ACTIVE_LOW != 0) begin : g_out_inv
    assign COUNT = ~value;
  end else begin : g_out_true
    assign COUNT = value;
  end

  assign TICK = tick_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Directed self-checking bench for updown_bcd_counter.
// u0: DIGITS=2, TICK_MAX=4, true polarity. u1: DIGITS=1, TICK_MAX=4, active-low output.
module tb_updown_bcd_counter;

  logic       clk;
  logic       reset0, run0, up, load0;
  logic [7:0] load_val0;
  logic [7:0] count0;
  logic       tick0, wrap0;
  logic       reset1, run1, load1;
  logic [3:0] load_val1;
  logic [3:0] count1;
  logic       tick1, wrap1;

  int checks   = 0;
  int failures = 0;

  updown_bcd_counter #(
    .DIGITS         (2),
    .TICK_MAX       (4),
    .OUT_ACTIVE_LOW (0)
  ) u0 (
    .CLK      (clk),
    .RESET    (reset0),
    .RUN      (run0),
    .UP       (up),
    .LOAD     (load0),
    .LOAD_VAL (load_val0),
    .COUNT    (count0),
    .TICK     (tick0),
    .WRAP     (wrap0)
  );

  updown_bcd_counter #(
    .DIGITS         (1),
    .TICK_MAX       (4),
    .OUT_ACTIVE_LOW (1)
  ) u1 (
    .CLK      (clk),
    .RESET    (reset1),
    .RUN      (run1),
    .UP       (up),
    .LOAD     (load1),
    .LOAD_VAL (load_val1),
    .COUNT    (count1),
    .TICK     (tick1),
    .WRAP     (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int n);
    logic [3:0] hi, lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  // Expected results of three consecutive steps from a loaded limit value.
`ifdef UPDOWN_BCD_SATURATE_EN
  logic [7:0] up_cnt [3] = '{8'h99, 8'h99, 8'h99};
  logic       up_wrp [3] = '{1'b1, 1'b1, 1'b1};
  logic [7:0] dn_cnt [3] = '{8'h00, 8'h00, 8'h00};
  logic       dn_wrp [3] = '{1'b1, 1'b1, 1'b1};
  logic [7:0] before_load = 8'h00;
`else
  logic [7:0] up_cnt [3] = '{8'h00, 8'h01, 8'h02};
  logic       up_wrp [3] = '{1'b1, 1'b0, 1'b0};
  logic [7:0] dn_cnt [3] = '{8'h99, 8'h98, 8'h97};
  logic       dn_wrp [3] = '{1'b1, 1'b0, 1'b0};
  logic [7:0] before_load = 8'h97;
`endif

  initial begin
    reset0 = 1'b0; run0 = 1'b0; up = 1'b1; load0 = 1'b0; load_val0 = 8'h00;
    reset1 = 1'b0; run1 = 1'b0; load1 = 1'b0; load_val1 = 4'h0;
    edge1();
    edge1();
    chk("rst_count", 32'(count0), 32'h00);
    chk("rst_tick", 32'(tick0), 32'h0);
    chk("rst_wrap", 32'(wrap0), 32'h0);
    chk("rst_count_al", 32'(count1), 32'hF);

    // Free run up: step k/4 after k edges, TICK on every 4th edge.
    reset0 = 1'b1; reset1 = 1'b1; run0 = 1'b1; up = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      edge1();
      chk("run_tick", 32'(tick0), 32'((k % 4) == 0));
      chk("run_count", 32'(count0), 32'(bcd2(k / 4)));
    end
    chk("run_final", 32'(count0), 32'h10);

    // Up from 99.
    load0 = 1'b1; load_val0 = 8'h99;
    edge1();
    chk("ld99_count", 32'(count0), 32'h99);
    chk("ld99_tick", 32'(tick0), 32'h0);
    load0 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      for (int e = 0; e < 3; e++) begin
        edge1();
        chk("up_wrap_idle", 32'(wrap0), 32'h0);
      end
      edge1();
      chk("up_step_count", 32'(count0), 32'(up_cnt[j]));
      chk("up_step_wrap", 32'(wrap0), 32'(up_wrp[j]));
      chk("up_step_tick", 32'(tick0), 32'h1);
    end

    // Down from 00.
    load0 = 1'b1; load_val0 = 8'h00; up = 1'b0;
    edge1();
    chk("ld00_count", 32'(count0), 32'h00);
    load0 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      for (int e = 0; e < 3; e++) begin
        edge1();
        chk("dn_wrap_idle", 32'(wrap0), 32'h0);
      end
      edge1();
      chk("dn_step_count", 32'(count0), 32'(dn_cnt[j]));
      chk("dn_step_wrap", 32'(wrap0), 32'(dn_wrp[j]));
    end

    // Load on the step cycle wins; 0xA nibble loads as 0.
    edge1(); edge1(); edge1();
    chk("pre_load_count", 32'(count0), 32'(before_load));
    load0 = 1'b1; load_val0 = 8'h5A; up = 1'b1;
    edge1();
    chk("ldstep_count", 32'(count0), 32'h50);
    chk("ldstep_tick", 32'(tick0), 32'h0);
    chk("ldstep_wrap", 32'(wrap0), 32'h0);
    load0 = 1'b0;
    for (int e = 0; e < 3; e++) begin
      edge1();
      chk("after_ld_tick", 32'(tick0), 32'h0);
    end
    edge1();
    chk("after_ld_count", 32'(count0), 32'h51);
    chk("after_ld_tick_hi", 32'(tick0), 32'h1);

    // Freeze with prescaler at 2.
    edge1(); edge1();
    run0 = 1'b0;
    for (int e = 0; e < 10; e++) begin
      edge1();
      chk("hold_count", 32'(count0), 32'h51);
      chk("hold_tick", 32'(tick0), 32'h0);
    end
    run0 = 1'b1;
    edge1();
    chk("resume_tick0", 32'(tick0), 32'h0);
    edge1();
    chk("resume_tick1", 32'(tick0), 32'h1);
    chk("resume_count", 32'(count0), 32'h52);

    // Down borrow across digits.
    load0 = 1'b1; load_val0 = 8'h20; up = 1'b0;
    edge1();
    load0 = 1'b0;
    edge1(); edge1(); edge1(); edge1();
    chk("borrow_count", 32'(count0), 32'h19);
    chk("borrow_wrap", 32'(wrap0), 32'h0);

    // Active-low single digit, mid-count reset.
    up = 1'b1;
    load1 = 1'b1; load_val1 = 4'h3;
    edge1();
    chk("al_load3", 32'(count1), 32'hC);
    load1 = 1'b0; run1 = 1'b1;
    edge1(); edge1();
    chk("al_hold3", 32'(count1), 32'hC);
    reset1 = 1'b0;
    edge1();
    reset1 = 1'b1;
    chk("al_reset_count", 32'(count1), 32'hF);
    chk("al_reset_tick", 32'(tick1), 32'h0);
    for (int e = 0; e < 3; e++) begin
      edge1();
      chk("al_restart_tick", 32'(tick1), 32'h0);
    end
    edge1();
    chk("al_first_tick", 32'(tick1), 32'h1);
    chk("al_first_count", 32'(count1), 32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
